// File: rtl/timer_array.sv
// Array of independent down-counting timer channels with prescaler, one-shot/periodic
// modes and a masked level interrupt, accessed through a small register file.
module timer_array #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 32
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [3:0]  ADD_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        IRQ
);

  localparam int unsigned PW = 8;

  localparam logic [1:0] REG_CTRL   = 2'b00;
  localparam logic [1:0] REG_PRESET = 2'b01;
  localparam logic [1:0] REG_COUNT  = 2'b10;

  logic [NCH-1:0]         en_q;
  logic [NCH-1:0][1:0]    mode_q;
  logic [NCH-1:0]         im_q;
  logic [NCH-1:0][PW-1:0] psc_q;
  logic [NCH-1:0][CW-1:0] preset_q;
  logic [NCH-1:0][CW-1:0] count_q;
  logic [NCH-1:0]         pend_q;
  logic [NCH-1:0][PW-1:0] pcnt_q;

  logic [NCH-1:0] run_c;
  logic [NCH-1:0] tick_c;
  logic [NCH-1:0] expire_c;

  // MODE[1] set means hold: no prescaler advance and no ticks
  always_comb begin
    run_c    = '0;
    tick_c   = '0;
    expire_c = '0;
    for (int i = 0; i < NCH; i++) begin
      run_c[i]    = en_q[i] && !mode_q[i][1];
      tick_c[i]   = run_c[i] && (pcnt_q[i] == psc_q[i]);
      expire_c[i] = tick_c[i] && (count_q[i] <= CW'(1));
    end
  end

  // Counting first, then register writes, so a same-edge software write overrides
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      en_q     <= '0;
      mode_q   <= '0;
      im_q     <= '0;
      psc_q    <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      pcnt_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (tick_c[i]) begin
          pcnt_q[i] <= '0;
          if (expire_c[i]) begin
            pend_q[i] <= 1'b1;
            if (mode_q[i][0]) begin
              count_q[i] <= preset_q[i];
            end else begin
              count_q[i] <= '0;
              en_q[i]    <= 1'b0;
            end
          end else begin
            count_q[i] <= count_q[i] - CW'(1);
          end
        end else if (run_c[i]) begin
          pcnt_q[i] <= pcnt_q[i] + PW'(1);
        end

        if (WE_I && (ADD_I[3:2] == 2'(i))) begin
          case (ADD_I[1:0])
            REG_CTRL: begin
              en_q[i]   <= DAT_I[0];
              mode_q[i] <= DAT_I[2:1];
              im_q[i]   <= DAT_I[3];
              psc_q[i]  <= DAT_I[15:8];
              if (!en_q[i] && DAT_I[0]) begin
                count_q[i] <= preset_q[i];
                pcnt_q[i]  <= '0;
              end
            end
            REG_PRESET: begin
              preset_q[i] <= DAT_I[CW-1:0];
              if (!en_q[i]) begin
                count_q[i] <= DAT_I[CW-1:0];
              end
            end
            REG_COUNT: begin
            end
            default: begin
              // an expiry on the same edge keeps PEND set
              if (DAT_I[0] && !expire_c[i]) begin
                pend_q[i] <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

  // Unimplemented channels fall through to zero
  always_comb begin
    DAT_O = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ADD_I[3:2] == 2'(i)) begin
        case (ADD_I[1:0])
          REG_CTRL:   DAT_O = {16'b0, psc_q[i], 4'b0, im_q[i], mode_q[i], en_q[i]};
          REG_PRESET: DAT_O = 32'(preset_q[i]);
          REG_COUNT:  DAT_O = 32'(count_q[i]);
          default:    DAT_O = {31'b0, pend_q[i]};
        endcase
      end
    end
  end

  assign IRQ = |(pend_q & im_q);

endmodule

// File: doc/timer_array.md
TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 Parameter NCH, default 4, number of independent timer channels (1..4).
REQ-002 Parameter CW, default 32, counter/preset width in bits (8..32).
REQ-003 CLK_I  input  1  system clock; all state changes on its rising edge.
REQ-004 RST_I  input  1  reset, asynchronous, active-high.
REQ-005 ADD_I  input  4  register address; [3:2] channel index, [1:0] register select.
REQ-006 WE_I  input  1  write enable; write occurs at the rising edge of CLK_I while asserted.
REQ-007 DAT_I  input  32  write data.
REQ-008 DAT_O  output  32  read data, combinational from ADD_I and current register state.
REQ-009 IRQ  output  1  interrupt request, level, combinational from registers.

Function
REQ-010 Each channel SHALL hold CTRL, PRESET (CW bits), COUNT (CW bits), PEND (1 bit), and an 8-bit prescale counter PCNT.
REQ-011 Register select SHALL be: 00 CTRL (R/W), 01 PRESET (R/W), 10 COUNT (read-only; writes ignored), 11 STAT (bit0 = PEND; write 1 to bit0 clears it, write 0 has no effect).
REQ-012 CTRL fields SHALL be: [0] EN, [2:1] MODE, [3] IM, [15:8] PSC; all other bits read 0 and are not stored.
REQ-013 PRESET/COUNT SHALL read zero-extended to 32 bits; DAT_I bits above CW-1 SHALL be ignored on write.
REQ-014 Channel index >= NCH SHALL read 0 and ignore writes.
REQ-015 MODE 00 = one-shot, 01 = periodic, 10/11 = hold (no ticks, COUNT frozen, EN unchanged).
REQ-016 Write to CTRL that changes EN 0->1 SHALL, at that edge, load COUNT<=PRESET and clear PCNT.
REQ-017 Write to PRESET while EN=0 SHALL also load COUNT with the new value at that edge; while EN=1 only PRESET changes.
REQ-018 While EN=1 and MODE in {00,01}: PCNT increments each cycle; when PCNT==PSC a tick occurs and PCNT<=0.
REQ-019 On tick with COUNT>1: COUNT<=COUNT-1.
REQ-020 Expiry = tick with COUNT<=1; one-shot expiry: COUNT<=0, EN<=0, PEND<=1; periodic expiry: COUNT<=PRESET, PEND<=1.
REQ-021 Resulting period with PSC=P, PRESET=N>=1 SHALL be exactly N*(P+1) cycles between expiries; PRESET=0 behaves as PRESET=1.
REQ-022 While EN=0, COUNT and PCNT SHALL hold.
REQ-023 IRQ SHALL equal OR over channels of (PEND & IM); clearing IM masks IRQ without clearing PEND.
REQ-024 Same-edge expiry and CTRL write to that channel: written CTRL value wins (including EN), expiry's COUNT/PEND effects still apply unless REQ-016 reload applies, which wins for COUNT.
REQ-025 Same-edge expiry and STAT write-1-clear: PEND SHALL be 1 (set wins).
REQ-026 Channels SHALL be fully independent; a write to one channel SHALL not affect another.

Reset
REQ-027 RST_I high SHALL immediately clear CTRL, PRESET, COUNT, PEND, PCNT of all channels; DAT_O then reads 0 for all addresses and IRQ=0.
REQ-028 Reset asserted mid-count SHALL abort counting; after release channels stay disabled until software sets EN.

Verification
REQ-029 One-shot: ch0 PRESET=5, CTRL=0x9 (EN,IM, mode 00, PSC 0) -> COUNT 5,4,3,2,1, then PEND=1, IRQ=1, EN reads 0, COUNT=0 exactly 5 cycles after enable write; stays 0.
REQ-030 Periodic+prescale: ch1 PRESET=3, CTRL=0x0000_020B (PSC=2, mode 01, EN, IM) -> expiry every 9 cycles, COUNT reloads 3, PEND set each period; W1C STAT between expiries drops IRQ until next expiry.
REQ-031 Collision: W1C to ch1 STAT on the same edge as expiry -> PEND remains 1, IRQ stays 1.
REQ-032 Masking/multi-channel: ch2 and ch3 both expire, IM=1 on ch3 only -> IRQ follows ch3 PEND; ch2 STAT reads 1, IRQ=0 after ch3 cleared.
REQ-033 Width/range: CW=8, write PRESET=0x1FF -> reads 0xFF; read ADD_I channel >= NCH (e.g. NCH=2, ADD_I=4'b1100) -> 0; write COUNT -> no change.
REQ-034 Reset mid-count: assert RST_I asynchronously with ch0 COUNT=3 -> all registers read 0 before next clock edge, IRQ=0; no expiry after release.
